// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: serial word input and parallel frame output.
//
// Handshake: in_valid qualifies in_sof and in_data for the cycle it is high;
// there is no ready, so the demux accepts every valid word. out_valid and
// frame_err are single-cycle pulses; out_data is held between completions.
interface tdm_demux_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_sof;
  logic [WIDTH-1:0]       in_data;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_valid;
  logic                   frame_err;

  // Source side: drives the serial stream, observes the frame output.
  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, frame_err
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, frame_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects LANES serial words into a shadow
// buffer and publishes the whole frame atomically on completion. The final
// word bypasses the shadow so the frame appears on the edge that samples it.
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        reset,
  tdm_demux_if.slave  bus,
  output logic        fsm_state  // 0 = IDLE, 1 = COLLECT
);
  localparam int SLOT_W = $clog2(LANES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

  typedef enum logic { IDLE = 1'b0, COLLECT = 1'b1 } state_t;

  state_t                          state, state_n;
  logic [SLOT_W-1:0]               slot, slot_n;
  logic [LANES-2:0][WIDTH-1:0]     shadow, shadow_n;
  logic [LANES*WIDTH-1:0]          out_data_q, out_data_n;
  logic                            out_valid_q, out_valid_n;
  logic                            frame_err_q, frame_err_n;

  // State and output registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      shadow      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      shadow      <= shadow_n;
      out_data_q  <= out_data_n;
      out_valid_q <= out_valid_n;
      frame_err_q <= frame_err_n;
    end
  end

  // Next-state logic: cycles without in_valid leave everything but the pulses untouched.
  always_comb begin
    state_n     = state;
    slot_n      = slot;
    shadow_n    = shadow;
    out_data_n  = out_data_q;
    out_valid_n = 1'b0;
    frame_err_n = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        IDLE: begin
          // Words outside a frame are dropped silently.
          if (bus.in_sof) begin
            shadow_n[0] = bus.in_data;
            slot_n      = SLOT_W'(1);
            state_n     = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.in_sof) begin
            // Early start: abandon the partial frame, restart at slot 0.
            frame_err_n = 1'b1;
            shadow_n[0] = bus.in_data;
            slot_n      = SLOT_W'(1);
          end else if (slot == LAST_SLOT) begin
            out_data_n  = {bus.in_data, shadow};
            out_valid_n = 1'b1;
            slot_n      = '0;
            state_n     = IDLE;
          end else begin
            for (int i = 0; i < LANES - 1; i++) begin
              if (slot == SLOT_W'(i)) shadow_n[i] = bus.in_data;
            end
            slot_n = slot + SLOT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign fsm_state     = state;
endmodule
